wormhole_output_alloc: RTL and testbench

//  Per-output-port allocator for the router switch. Shares one output port among IN_N input ports.
//  - Arbitrates head flits with matrix (round-robin) priority.
//  - Locks the winner until its tail flit has passed (wormhole).
//  - Gates every flit transfer on downstream credits.
//  - Drives the crossbar select and the input-FIFO pop / downstream push strobe.

---
 rtl/noc_alloc_pkg.sv | 18 +
 rtl/matrix_arbiter.sv | 60 ++++++
 rtl/wormhole_output_alloc.sv | 139 +++++++++++++
 tb/tb_wormhole_output_alloc.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_alloc_pkg.sv
// rtl/noc_alloc_pkg.sv - shared state type and width helpers for the output allocator
package noc_alloc_pkg;

  typedef enum logic {
    ALLOC_IDLE   = 1'b0,
    ALLOC_LOCKED = 1'b1
  } alloc_state_e;

  function automatic int credit_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Keeps index ports at least one bit wide when only one requester exists.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matrix_arbiter.sv
// rtl/matrix_arbiter.sv - matrix round-robin arbiter; the winner drops to lowest priority
module matrix_arbiter
  import noc_alloc_pkg::*;
#(
  parameter int  N  = 5,
  localparam int IW = id_w(N)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [N-1:0]  req_i,
  output logic          gnt_vld_o,
  output logic [IW-1:0] gnt_id_o
);

  // prio_q[i][j] set means requester i currently beats requester j.
  logic [N-1:0][N-1:0] prio_q, prio_d;
  logic [N-1:0]        gnt;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      gnt[i] = req_i[i];
      for (int j = 0; j < N; j++) begin
        if (req_i[j] && prio_q[j][i]) gnt[i] = 1'b0;
      end
    end
  end

  always_comb begin
    gnt_vld_o = |gnt;
    gnt_id_o  = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) gnt_id_o = IW'(i);
    end
  end

  always_comb begin
    prio_d = prio_q;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) begin
        for (int j = 0; j < N; j++) begin
          prio_d[i][j] = 1'b0;
          if (j != i) prio_d[j][i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          prio_q[i][j] <= (i < j);
        end
      end
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/wormhole_output_alloc.sv
// rtl/wormhole_output_alloc.sv - wormhole output-port allocator with downstream credit gating
// Define ALLOC_ERR_EN to add the sticky err_o protocol-error flag.
module wormhole_output_alloc
  import noc_alloc_pkg::*;
#(
  parameter int  IN_N      = 5,
  parameter int  BUF_DEPTH = 4,
  localparam int IW        = id_w(IN_N),
  localparam int CW        = credit_w(BUF_DEPTH)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [IN_N-1:0] req_i,
  input  logic [IN_N-1:0] head_i,
  input  logic [IN_N-1:0] tail_i,
  input  logic            credit_i,
  output logic [IN_N-1:0] grant_o,
  output logic [IW-1:0]   grant_id_o,
  output logic            fwd_vld_o,
  output logic            busy_o,
  output logic [CW-1:0]   credit_cnt_o
`ifdef ALLOC_ERR_EN
  ,
  output logic            err_o
`endif
);

  alloc_state_e    state_q, state_d;
  logic [IN_N-1:0] grant_q, grant_d;
  logic [IW-1:0]   grant_id_q, grant_id_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IN_N-1:0] arb_req;
  logic            arb_vld;
  logic [IW-1:0]   arb_id;
  logic            owner_req, owner_tail;

  // Gating on IDLE keeps the priority matrix frozen for the whole packet.
  assign arb_req = req_i & head_i & {IN_N{state_q == ALLOC_IDLE}};

  matrix_arbiter #(.N(IN_N)) u_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (arb_req),
    .gnt_vld_o (arb_vld),
    .gnt_id_o  (arb_id)
  );

  assign owner_req  = |(req_i & grant_q);
  assign owner_tail = |(tail_i & grant_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ALLOC_IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      cnt_q      <= CW'(BUF_DEPTH);
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    case (state_q)
      ALLOC_IDLE: begin
        if (arb_vld) begin
          state_d    = ALLOC_LOCKED;
          grant_d    = IN_N'(1) << arb_id;
          grant_id_d = arb_id;
        end
      end
      ALLOC_LOCKED: begin
        if (fwd_vld_o && owner_tail) begin
          state_d    = ALLOC_IDLE;
          grant_d    = '0;
          grant_id_d = '0;
        end
      end
      default: state_d = ALLOC_IDLE;
    endcase
  end

  always_comb begin
    busy_o    = (state_q == ALLOC_LOCKED);
    fwd_vld_o = busy_o && owner_req && (cnt_q != '0);
  end

  // A returned credit at full count is dropped rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (fwd_vld_o && !credit_i) begin
      cnt_d = cnt_q - CW'(1);
    end else if (!fwd_vld_o && credit_i && (cnt_q != CW'(BUF_DEPTH))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign grant_o      = grant_q;
  assign grant_id_o   = grant_id_q;
  assign credit_cnt_o = cnt_q;

`ifdef ALLOC_ERR_EN
  logic first_q, first_d;
  logic err_q, err_d;
  logic owner_head;

  assign owner_head = |(head_i & grant_q);

  always_comb begin
    first_d = first_q;
    if ((state_q == ALLOC_IDLE) && arb_vld) begin
      first_d = 1'b1;
    end else if (fwd_vld_o) begin
      first_d = 1'b0;
    end
    err_d = err_q
          | (credit_i & (cnt_q == CW'(BUF_DEPTH)) & ~fwd_vld_o)
          | (fwd_vld_o & owner_head & ~first_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      first_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      first_q <= first_d;
      err_q   <= err_d;
    end
  end

  assign err_o = err_q;
`endif

endmodule

// File: tb/tb_wormhole_output_alloc.sv
// tb/tb_wormhole_output_alloc.sv - bench for wormhole_output_alloc against a queue-based reference model
module tb_wormhole_output_alloc;

  localparam int IN_N      = 5;
  localparam int BUF_DEPTH = 4;
  localparam int IW        = 3;
  localparam int CW        = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [IN_N-1:0] req = '0, head = '0, tail = '0;
  logic            credit = 1'b0;
  logic [IN_N-1:0] grant;
  logic [IW-1:0]   grant_id;
  logic            fwd, busy;
  logic [CW-1:0]   cnt;
`ifdef ALLOC_ERR_EN
  logic            err;
`endif

  always #5 clk = ~clk;

  wormhole_output_alloc #(.IN_N(IN_N), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_i        (req),
    .head_i       (head),
    .tail_i       (tail),
    .credit_i     (credit),
    .grant_o      (grant),
    .grant_id_o   (grant_id),
    .fwd_vld_o    (fwd),
    .busy_o       (busy),
    .credit_cnt_o (cnt)
`ifdef ALLOC_ERR_EN
    ,
    .err_o        (err)
`endif
  );

  int tests = 0;
  int fails = 0;
  bit cmp_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: owner index (-1 = free), priority list highest first, credit count.
  int m_owner;
  int m_order[$];
  int m_cnt;
  bit m_err;
  bit m_first;
  int pop_idx = -1;

  function automatic void m_reset();
    m_owner = -1;
    m_order = {};
    for (int i = 0; i < IN_N; i++) m_order.push_back(i);
    m_cnt   = BUF_DEPTH;
    m_err   = 0;
    m_first = 0;
    pop_idx = -1;
  endfunction

  function automatic bit m_fwd();
    return (m_owner >= 0) && req[m_owner] && (m_cnt > 0);
  endfunction

  function automatic void m_step();
    bit f;
    int wk;
    int w;
    f = m_fwd();
    pop_idx = f ? m_owner : -1;
    if (m_owner < 0) begin
      wk = -1;
      for (int k = 0; k < m_order.size(); k++)
        if (wk < 0 && req[m_order[k]] && head[m_order[k]]) wk = k;
      if (wk >= 0) begin
        w = m_order[wk];
        m_order.delete(wk);
        m_order.push_back(w);
        m_owner = w;
        m_first = 1;
      end
    end else begin
      if (f && head[m_owner] && !m_first) m_err = 1;
      if (f) m_first = 0;
      if (f && tail[m_owner]) m_owner = -1;
    end
    if (credit && m_cnt == BUF_DEPTH && !f) m_err = 1;
    m_cnt = m_cnt - int'(f) + int'(credit);
    if (m_cnt > BUF_DEPTH) m_cnt = BUF_DEPTH;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) m_reset();
    else        m_step();
  end

  always @(negedge rst_n) m_reset();

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("grant", grant, (m_owner < 0) ? 0 : (1 << m_owner));
      chk("busy", busy, m_owner >= 0);
      chk("fwd", fwd, m_fwd());
      chk("credit_cnt", cnt, m_cnt);
      if (m_owner >= 0) chk("grant_id", grant_id, m_owner);
`ifdef ALLOC_ERR_EN
      chk("err", err, m_err);
`endif
    end
  end

  // Upstream packet sources: rem = flits left, len = packet length.
  int rem[IN_N];
  int len[IN_N];
  bit rand_en = 0;
  int cmode = 0;

  task automatic drive();
    for (int i = 0; i < IN_N; i++) begin
      req[i]  = (rem[i] > 0) && !(rand_en && ($urandom_range(7) == 0));
      head[i] = (rem[i] > 0) && (rem[i] == len[i]);
      tail[i] = (rem[i] == 1);
    end
  endtask

  task automatic load(input int i, input int l);
    rem[i] = l;
    len[i] = l;
  endtask

  task automatic clear_src();
    for (int i = 0; i < IN_N; i++) begin
      rem[i] = 0;
      len[i] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (pop_idx >= 0 && rem[pop_idx] > 0) rem[pop_idx]--;
    if (rand_en)
      for (int i = 0; i < IN_N; i++)
        if (rem[i] == 0 && $urandom_range(3) == 0) load(i, $urandom_range(6, 1));
    case (cmode)
      0: credit = 1'b0;
      1: credit = (pop_idx >= 0);
      2: credit = (m_cnt < BUF_DEPTH);
      default: credit = ((m_cnt < BUF_DEPTH) && ($urandom_range(1) == 1)) || ($urandom_range(63) == 0);
    endcase
    drive();
  endtask

  function automatic bit all_idle();
    int s = 0;
    for (int i = 0; i < IN_N; i++) s += rem[i];
    return (s == 0) && (m_owner < 0) && (m_cnt == BUF_DEPTH);
  endfunction

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while (!all_idle() && n < budget) begin
      tick();
      n++;
    end
    chk(nm, all_idle(), 1);
  endtask

  int t2_id[9]  = '{-1, 0, 0, 0, -1, 2, 2, 2, -1};
  int t2_fw[9]  = '{0, 1, 1, 1, 0, 1, 1, 1, 0};
  int t3_id[7]  = '{-1, 0, 0, -1, 2, 2, -1};
  int t4_fw[11] = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 0};
  int t4_cn[11] = '{4, 4, 3, 2, 1, 0, 0, 0, 0, 1, 0};

  initial begin
    clear_src();
    m_reset();
    #1 rst_n = 1'b0;
    #1 cmp_en = 1;
    chk("t1_grant", grant, 0);
    chk("t1_busy", busy, 0);
    chk("t1_cnt", cnt, BUF_DEPTH);
    chk("t1_fwd", fwd, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Two simultaneous 3-flit heads, credits echoed back one cycle later.
    cmode = 1;
    tick();
    load(0, 3);
    load(2, 3);
    drive();
    for (int k = 0; k < 9; k++) begin
      if (k > 0) tick();
      #2;
      chk("t2_grant", grant, (t2_id[k] < 0) ? 0 : (1 << t2_id[k]));
      chk("t2_fwd", fwd, t2_fw[k]);
    end

    // Input 2 was served last, so input 0 outranks it now.
    tick();
    load(0, 2);
    load(2, 2);
    drive();
    for (int k = 0; k < 7; k++) begin
      if (k > 0) tick();
      #2;
      chk("t3_grant", grant, (t3_id[k] < 0) ? 0 : (1 << t3_id[k]));
    end

    // Six-flit packet with no returned credits, then a single credit pulse.
    cmode = 0;
    tick();
    load(1, 6);
    drive();
    for (int k = 0; k < 11; k++) begin
      if (k > 0) tick();
      if (k == 8) credit = 1'b1;
      #2;
      chk("t4_fwd", fwd, t4_fw[k]);
      chk("t4_cnt", cnt, t4_cn[k]);
      if (k > 0) chk("t4_busy", busy, 1);
    end
    cmode = 2;
    wait_idle("t4_drain", 50);

    // Single-flit packet.
    cmode = 0;
    tick();
    load(4, 1);
    drive();
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      #2;
      chk("t5_busy", busy, k == 1);
      chk("t5_fwd", fwd, k == 1);
      chk("t5_grant", grant, (k == 1) ? 16 : 0);
      chk("t5_cnt", cnt, (k == 2) ? 3 : 4);
    end
    cmode = 2;
    wait_idle("t5_drain", 50);

    // Reset dropped mid-packet, away from any clock edge.
    tick();
    load(3, 5);
    drive();
    tick();
    tick();
    #2;
    chk("t6_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_grant", grant, 0);
    chk("t6_busy", busy, 0);
    chk("t6_fwd", fwd, 0);
    chk("t6_cnt", cnt, BUF_DEPTH);
    chk("t6_gid", grant_id, 0);
    clear_src();
    drive();
    tick();
    rst_n = 1'b1;
    tick();

`ifdef ALLOC_ERR_EN
    cmode = 0;
    tick();
    credit = 1'b1;
    #2;
    chk("e_pre", err, 0);
    tick();
    #2;
    chk("e_set", err, 1);
    chk("e_cnt", cnt, BUF_DEPTH);
    tick();
    tick();
    #2;
    chk("e_hold", err, 1);
    rst_n = 1'b0;
    #1;
    chk("e_clr", err, 0);
    tick();
    rst_n = 1'b1;
    tick();
`endif

    // Randomized traffic with bubbles, random credits and one mid-run reset.
    rand_en = 1;
    cmode   = 3;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (c == 1500) begin
        #2;
        rst_n = 1'b0;
        clear_src();
        drive();
        tick();
        rst_n = 1'b1;
      end
    end
    rand_en = 0;
    cmode   = 2;
    tick();
    wait_idle("rand_drain", 400);

    cmp_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
